// File: rtl/qos_pop_scheduler_if.sv
// qos_pop_scheduler_if: control, FIFO-status and read-strobe bundle of the QoS pop scheduler.
interface qos_pop_scheduler_if #(
  parameter int WEIGHT_W = 5
);
  logic                  init_i;
  logic [4*WEIGHT_W-1:0] weights_i;
  logic [3:0]            empty_i;
  logic                  pause_i;
  logic [3:0]            pop_o;
  logic [1:0]            pop_id_o;
  logic                  pop_valid_o;
  logic                  round_o;
  logic                  idle_o;
  modport master (
    output init_i, weights_i, empty_i, pause_i,
    input  pop_o, pop_id_o, pop_valid_o, round_o, idle_o
  );
  modport slave (
    input  init_i, weights_i, empty_i, pause_i,
    output pop_o, pop_id_o, pop_valid_o, round_o, idle_o
  );
endinterface

// File: rtl/qos_pop_scheduler.sv
// qos_pop_scheduler: weighted round-robin read scheduler for the four QoS class FIFOs.
module qos_pop_scheduler #(
  parameter int WEIGHT_W = 5,
  parameter int NQ = 4
) (
  input logic clk,
  input logic rst_n,
  qos_pop_scheduler_if.slave sif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  logic [1:0] state_q, state_d, ptr_q, ptr_d, pop_id_q, pop_id_d;
  logic [3:0] pop_q, pop_d, elig;
  logic pop_valid_q, pop_valid_d, round_q, round_d, refill;
  logic [WEIGHT_W-1:0] weight_q [NQ];
  logic [WEIGHT_W-1:0] weight_d [NQ];
  logic [WEIGHT_W-1:0] credit_q [NQ];
  logic [WEIGHT_W-1:0] credit_d [NQ];
  logic [2:0] scan_idle, scan_wait;

  // returns {found, index} of the first set bit at or after start, wrapping 3->0
  function automatic logic [2:0] scan(input logic [1:0] start, input logic [3:0] el);
    logic [2:0] r;
    r = '0;
    for (int k = 3; k >= 0; k--)
      if (el[start + 2'(k)]) r = {1'b1, start + 2'(k)};
    return r;
  endfunction

  always_comb begin
    elig = '0;
    refill = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      elig[i] = !sif.empty_i[i] && credit_q[i] != '0;
      refill = refill | (!sif.empty_i[i] && weight_q[i] != '0);
    end
  end

  assign scan_idle = scan(ptr_q, elig);
  assign scan_wait = scan(pop_id_q + 2'd1, elig);

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    pop_id_d = pop_id_q;
    pop_valid_d = 1'b0;
    round_d = 1'b0;
    weight_d = weight_q;
    credit_d = credit_q;
    if (sif.init_i) begin
      for (int i = 0; i < NQ; i++) begin
        weight_d[i] = sif.weights_i[i*WEIGHT_W +: WEIGHT_W];
        credit_d[i] = sif.weights_i[i*WEIGHT_W +: WEIGHT_W];
      end
      ptr_d = '0;
      state_d = S_IDLE;
    end else if (state_q == S_POP) begin
      credit_d[pop_id_q] = credit_q[pop_id_q] - WEIGHT_W'(credit_q[pop_id_q] != '0);
      pop_valid_d = 1'b1;
      state_d = S_WAIT;
    end else if (state_q == S_IDLE) begin
      if (!sif.pause_i && scan_idle[2]) begin
        state_d = S_POP;
        pop_id_d = scan_idle[1:0];
      end else if (!scan_idle[2] && refill) begin
        credit_d = weight_q;
        round_d = 1'b1;
      end
    end else if (!sif.pause_i && elig[pop_id_q]) begin
      state_d = S_POP;
    end else begin
      // moving on: the round-robin start point passes the queue just served
      ptr_d = pop_id_q + 2'd1;
      state_d = (!sif.pause_i && scan_wait[2]) ? S_POP : S_IDLE;
      pop_id_d = (!sif.pause_i && scan_wait[2]) ? scan_wait[1:0] : pop_id_q;
    end
    pop_d = (state_d == S_POP) ? 4'b0001 << pop_id_d : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      pop_id_q <= '0;
      pop_q <= '0;
      pop_valid_q <= 1'b0;
      round_q <= 1'b0;
      for (int i = 0; i < NQ; i++) begin
        weight_q[i] <= WEIGHT_W'(1);
        credit_q[i] <= WEIGHT_W'(1);
      end
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      pop_id_q <= pop_id_d;
      pop_q <= pop_d;
      pop_valid_q <= pop_valid_d;
      round_q <= round_d;
      weight_q <= weight_d;
      credit_q <= credit_d;
    end

  assign sif.pop_o = pop_q;
  assign sif.pop_id_o = pop_id_q;
  assign sif.pop_valid_o = pop_valid_q;
  assign sif.round_o = round_q;
  assign sif.idle_o = state_q == S_IDLE;
endmodule

// File: tb/tb_qos_pop_scheduler.sv
// tb_qos_pop_scheduler: scoreboard bench with a transaction-level WRR model and FIFO occupancy model.
module tb_qos_pop_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  qos_pop_scheduler_if #(.WEIGHT_W(5)) sif();
  qos_pop_scheduler #(.WEIGHT_W(5)) dut (.clk(clk), .rst_n(rst_n), .sif(sif));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cnt [4];
  int exp_q [$];
  int ev [$];
  int m_w [4], m_c [4];
  int m_ptr, m_ph, m_id, last_id;
  logic e_val, e_round;

  assign sif.empty_i = {cnt[3] == 0, cnt[2] == 0, cnt[1] == 0, cnt[0] == 0};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit can_pop(int q);
    return !sif.empty_i[q] && m_c[q] > 0;
  endfunction

  function automatic int choose(int start);
    for (int k = 0; k < 4; k++)
      if (can_pop((start + k) % 4)) return (start + k) % 4;
    return -1;
  endfunction

  function automatic bit reloadable();
    for (int q = 0; q < 4; q++)
      if (!sif.empty_i[q] && m_w[q] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mreset();
    m_w = '{1, 1, 1, 1};
    m_c = '{1, 1, 1, 1};
    m_ptr = 0; m_ph = 0; m_id = 0;
    e_val = 1'b0; e_round = 1'b0;
    exp_q.delete();
  endtask

  task automatic grant(int q);
    m_ph = 1;
    m_id = q;
    exp_q.push_back(q);
  endtask

  // m_ph: 0 = no pop outstanding, 1 = strobe on the FIFO, 2 = data on the bus
  task automatic step();
    int g;
    e_val = 1'b0;
    e_round = 1'b0;
    if (sif.init_i) begin
      for (int q = 0; q < 4; q++) m_w[q] = int'(sif.weights_i[q*5 +: 5]);
      m_c = m_w;
      m_ptr = 0;
      m_ph = 0;
    end else if (m_ph == 0) begin
      g = choose(m_ptr);
      if (!sif.pause_i && g >= 0) grant(g);
      else if (g < 0 && reloadable()) begin
        m_c = m_w;
        e_round = 1'b1;
      end
    end else if (m_ph == 1) begin
      if (m_c[m_id] > 0) m_c[m_id]--;
      m_ph = 2;
      e_val = 1'b1;
    end else if (!sif.pause_i && can_pop(m_id)) grant(m_id);
    else begin
      m_ptr = (m_id + 1) % 4;
      g = choose(m_ptr);
      if (!sif.pause_i && g >= 0) grant(g);
      else m_ph = 0;
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk);
      if (!rst_n) mreset();
      else step();
    end
  end

  initial begin
    int id;
    last_id = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("idle", int'(sif.idle_o), int'(m_ph == 0));
        chk("round", int'(sif.round_o), int'(e_round));
        chk("pop_valid", int'(sif.pop_valid_o), int'(e_val));
        if (sif.pop_valid_o) chk("valid_id", int'(sif.pop_id_o), last_id);
        if (sif.round_o) ev.push_back(9);
        if (sif.pop_o == 4'b0000) chk("pop_missing", exp_q.size(), 0);
        else begin
          id = 0;
          for (int q = 0; q < 4; q++) if (sif.pop_o[q]) id = q;
          chk("pop_onehot", int'($onehot(sif.pop_o)), 1);
          chk("pop_id", int'(sif.pop_id_o), id);
          chk("pop_nonempty", int'(cnt[id] > 0), 1);
          if (exp_q.size() == 0) chk("pop_unexpected", id, -1);
          else chk("pop_queue", id, exp_q.pop_front());
          ev.push_back(id);
          last_id = id;
          if (cnt[id] > 0) cnt[id]--;
        end
      end
    end
  end

  task automatic wait_for(input bit want_valid);
    for (int i = 0; i < 30 && !(want_valid ? sif.pop_valid_o : |sif.pop_o); i++) @(negedge clk);
    chk(want_valid ? "wait_valid" : "wait_pop", int'(want_valid ? sif.pop_valid_o : |sif.pop_o), 1);
  endtask

  task automatic do_init(input logic [19:0] w, input int fill);
    sif.weights_i = w;
    sif.init_i = 1'b1;
    cnt = '{fill, fill, fill, fill};
    ev.delete();
    @(negedge clk);
    #1 sif.init_i = 1'b0;
  endtask

  function automatic int nines();
    int n = 0;
    foreach (ev[i]) if (ev[i] == 9) n++;
    return n;
  endfunction

  initial begin
    int pat3 [11] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 9};
    int pat4 [4] = '{0, 2, 3, 9};
    int ones;
    rst_n = 1'b0;
    sif.init_i = 1'b0;
    sif.pause_i = 1'b0;
    sif.weights_i = '0;
    cnt = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst_pop", int'(sif.pop_o), 0);
    chk("rst_valid", int'(sif.pop_valid_o), 0);
    chk("rst_round", int'(sif.round_o), 0);
    chk("rst_idle", int'(sif.idle_o), 1);
    chk("rst_pop_id", int'(sif.pop_id_o), 0);

    cnt[0] = 3;
    wait_for(1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pop", int'(sif.pop_o), 0);
    chk("async_valid", int'(sif.pop_valid_o), 0);
    chk("async_idle", int'(sif.idle_o), 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cnt = '{0, 0, 0, 0};
    ev.delete();
    repeat (20) @(negedge clk);
    chk("empty_no_round", nines(), 0);
    chk("empty_idle", int'(sif.idle_o), 1);

    #1 do_init({5'd4, 5'd3, 5'd2, 5'd1}, 10);
    repeat (60) @(negedge clk);
    chk("wrr_len", int'(ev.size() >= 22), 1);
    for (int i = 0; i < 22 && i < ev.size(); i++) chk("wrr_order", ev[i], pat3[i % 11]);

    #1 do_init({5'd1, 5'd1, 5'd0, 5'd1}, 50);
    repeat (50) @(negedge clk);
    ones = 0;
    foreach (ev[i]) if (ev[i] == 1) ones++;
    chk("w0_never", ones, 0);
    chk("w0_len", int'(ev.size() >= 12), 1);
    for (int i = 0; i < 12 && i < ev.size(); i++) chk("w0_order", ev[i], pat4[i % 4]);

    wait_for(1'b1);
    #1 do_init({5'd0, 5'd0, 5'd0, 5'd5}, 50);
    chk("init_valid_drop", int'(sif.pop_valid_o), 0);
    chk("init_idle", int'(sif.idle_o), 1);
    repeat (30) @(negedge clk);
    chk("init5_len", int'(ev.size() >= 6), 1);
    for (int i = 0; i < 6 && i < ev.size(); i++) chk("init5_order", ev[i], i < 5 ? 0 : 9);

    #1 do_init({5'd2, 5'd2, 5'd2, 5'd2}, 10);
    wait_for(1'b0);
    #1 sif.pause_i = 1'b1;
    ev.delete();
    @(negedge clk);
    chk("pause_valid", int'(sif.pop_valid_o), 1);
    repeat (10) @(negedge clk);
    chk("pause_no_pop", ev.size(), 0);
    #1 sif.pause_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("pause_resume", ev.size() > 0 ? ev[0] : -1, 1);

    for (int c = 0; c < 3000; c++) begin
      #1;
      sif.pause_i = $urandom_range(3) == 0;
      sif.init_i = $urandom_range(150) == 0;
      if (sif.init_i)
        sif.weights_i = {5'($urandom_range(5)), 5'($urandom_range(5)), 5'($urandom_range(5)), 5'($urandom_range(5))};
      for (int q = 0; q < 4; q++)
        if ($urandom_range(9) == 0 && cnt[q] < 20) cnt[q] += $urandom_range(1, 3);
      @(negedge clk);
    end
    #1;
    sif.pause_i = 1'b0;
    sif.init_i = 1'b0;
    repeat (30) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qos_pop_scheduler.md
Name: qos_pop_scheduler

Overview:
- Weighted round-robin pop scheduler for the four class FIFOs of the QoS block. Decides which FIFO is read and when; drives the per-FIFO read strobes from weights programmed at init.
- Honours FIFO empty flags and the downstream pause from the flow-control FSM.
- Tags every popped byte with its queue id and a valid strobe.

Parameters:
- WEIGHT_W, 5, width of each per-queue weight (pops per round); weight 0 = queue disabled.
- NQ, 4, number of queues; fixed at 4, not to be overridden.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INIT  in  1  synchronous; latch WEIGHTS and restart scheduling.
- WEIGHTS  in  NQ*WEIGHT_W (20)  queue i weight at bits [i*WEIGHT_W +: WEIGHT_W].
- EMPTY  in  4  per-FIFO empty flag, bit i = FIFO i.
- PAUSE  in  1  downstream backpressure; 1 = issue no new pops.
- POP  out  4  one-hot FIFO read strobe, registered, one cycle wide.
- POP_ID  out  2  index of the queue in the current/last grant.
- POP_VALID  out  1  FIFO data valid; cycle after POP.
- ROUND  out  1  one-cycle pulse when credits are reloaded.
- IDLE  out  1  1 while in state S_IDLE.

Behaviour:
- Reset (RESET=0, async): state=S_IDLE, POP=0, POP_ID=0, POP_VALID=0, ROUND=0, IDLE=1, ptr=0, weight regs=1 each, credits=1 each.
- Internal state:
  - weight[i] and credit[i], both WEIGHT_W bits.
  - ptr (2-bit), the round-robin start point.
- Eligible(i) = !EMPTY[i] && credit[i]!=0.
- Selection: first eligible queue scanning ptr, ptr+1, ... modulo 4 (wrap 3->0).
- States:
  - S_IDLE:
    - POP=0, POP_VALID=0.
    - If PAUSE=0 and some queue is eligible: load POP_ID=sel, POP=onehot(sel), go S_POP.
    - Else if no queue eligible but some i has !EMPTY[i] && weight[i]!=0: credit[i]=weight[i] for all i, ROUND=1 for one cycle, stay S_IDLE.
    - Else stay.
  - S_POP:
    - POP asserted exactly this cycle.
    - credit[POP_ID] decrements by 1; never wraps below 0.
    - Always go S_WAIT; PAUSE does not cancel an issued pop.
  - S_WAIT:
    - POP=0, POP_VALID=1.
    - Same-queue continue: if PAUSE=0 and Eligible(POP_ID) (using updated credit and current EMPTY), re-pop the same queue → S_POP.
    - Otherwise: ptr=POP_ID+1 mod 4.
      - If PAUSE=0 and another queue is eligible (scan from new ptr), grant it → S_POP.
      - Else → S_IDLE.
- Throughput: max one pop per 2 cycles. The S_WAIT bubble guarantees EMPTY reflects the previous pop before the next decision.
- Data latency: POP at cycle t → POP_VALID at t+1 with POP_ID unchanged.
- Disabled queue (weight 0): never granted, even when non-empty.
- All queues empty: remain S_IDLE, no ROUND pulse.
- INIT=1 (any state, priority over all transitions):
  - weight[i]=WEIGHTS slice, credit[i]=weight[i], ptr=0.
  - POP=0, POP_VALID=0, ROUND=0, state=S_IDLE next cycle.
  - A pop issued in the same cycle as INIT still completes at the FIFO; its data is not flagged valid.
- RESET asserted mid-operation: outputs go to reset values immediately (asynchronous), without waiting for a clock.
- Invariants:
  - POP is zero or one-hot.
  - POP is never asserted on a queue whose EMPTY was 1 at the decision edge.
  - POP and POP_VALID are never both 1.

Test Plan:
- Reset: RESET=0 mid-S_POP → POP=0, POP_VALID=0, IDLE=1 without waiting for a clock edge; release, EMPTY=4'hF → stays idle, ROUND never pulses.
- Weights 1/2/3/4 via INIT, all FIFOs hold 10 bytes, PAUSE=0 → POP_ID order 0,1,1,2,2,2,3,3,3,3; ROUND pulse; order repeats; POP high every other cycle.
- Equal weights 1, only FIFO 2 non-empty with 3 bytes → three pops of queue 2, a ROUND pulse before each re-grant; then S_IDLE after EMPTY[2]=1.
- PAUSE raised during S_POP → that pop completes, POP_VALID=1 next cycle, then no POP until PAUSE=0; scheduling resumes at the next eligible queue after the paused queue.
- Weight 0 on queue 1, all queues non-empty → queue 1 never granted over 50 cycles; POP_ID cycles 0,2,3.
- INIT pulsed while in S_WAIT with new weights 5/0/0/0 → POP_VALID drops, S_IDLE, next grants queue 0 five times before the next ROUND pulse.
